// File: rtl/alu_issue.sv
// Issue/writeback controller for an external combinational ALU: latches one
// instruction, presents operands for one cycle, then writes the result back.
module alu_issue #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [8:0]    instr,
  input  logic          ld_en,
  input  logic [1:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [2:0]    alu_cmd,
  output logic [1:0]    ALU_Op,
  output logic [DW-1:0] inA,
  output logic [DW-1:0] inB,
  input  logic [DW-1:0] rslt,
  input  logic          zero,
  output logic          zero_flag,
  output logic          done,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t        state_q;
  logic [8:0]    instr_q;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] res_q;
  logic          zq_q;
  logic          zero_flag_q;

  logic [1:0] op_w, ra_w, rb_w;
  logic [2:0] cmd_w;
  logic       is_nop_w;

  assign op_w     = instr_q[8:7];
  assign cmd_w    = instr_q[6:4];
  assign ra_w     = instr_q[3:2];
  assign rb_w     = instr_q[1:0];
  assign is_nop_w = (op_w == 2'b00) && (cmd_w == 3'b110);

  // A pending load blocks acceptance for this cycle; reset masks readiness.
  assign in_ready  = (state_q == IDLE) && !ld_en && !reset;
  assign done      = (state_q == WB);
  assign zero_flag = zero_flag_q;
  assign dbg_data  = regs_q[dbg_addr];

  always_comb begin
    alu_cmd = 3'b110;
    ALU_Op  = 2'b00;
    inA     = '0;
    inB     = '0;
    if (state_q == EXEC) begin
      alu_cmd = cmd_w;
      ALU_Op  = op_w;
      inA     = regs_q[ra_w];
      inB     = regs_q[rb_w];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      res_q       <= '0;
      zq_q        <= 1'b0;
      zero_flag_q <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_en) begin
            regs_q[ld_addr] <= ld_data;
          end else if (in_valid) begin
            instr_q <= instr;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= rslt;
          zq_q    <= zero;
          state_q <= WB;
        end
        WB: begin
          if (!is_nop_w) begin
            regs_q[ra_w] <= res_q;
            zero_flag_q  <= zq_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: a behavioural ALU drives rslt/zero, the
// stimulus process predicts outcomes, a monitor compares at negedges.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] instr = '0;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [2:0] alu_cmd;
  logic [1:0] ALU_Op;
  logic [7:0] inA, inB;
  logic [7:0] rslt;
  logic       zero;
  logic       zero_flag;
  logic       done;
  logic [1:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int checks = 0;
  int failures = 0;

  alu_issue #(.DW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_cmd(alu_cmd), .ALU_Op(ALU_Op), .inA(inA), .inB(inB),
    .rslt(rslt), .zero(zero), .zero_flag(zero_flag), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [2:0] cmd,
                                       input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      2'b00: case (cmd)
        3'd0: r = a + b;
        3'd1: r = a << b[2:0];
        3'd2: r = a >> b[2:0];
        3'd3: r = a & b;
        3'd4: r = a | b;
        3'd5: r = a ^ b;
        3'd6: r = a;
        default: r = ~a;
      endcase
      2'b01: r = a + b + {5'd0, cmd};
      2'b10: r = (cmd == 3'd0) ? a + 8'd1 : a - 8'd1;
      default: r = (cmd == 3'd0) ? a - b : b - a;
    endcase
    return r;
  endfunction

  assign rslt = alu_f(ALU_Op, alu_cmd, inA, inB);
  assign zero = (rslt == 8'h00);

  typedef struct {logic [1:0] op; logic [2:0] cmd; logic [7:0] a; logic [7:0] b;} ex_t;
  typedef struct {logic [1:0] ra; logic [7:0] val; logic zf;} wb_t;

  ex_t exec_q[$];
  wb_t wb_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model state, owned by the stimulus process.
  logic [7:0] mR [4];
  logic       mzf = 1'b0;
  int         busy = 0;
  bit         exp_ready = 1'b0;
  wb_t        pend;

  task automatic cycle(input bit v, input logic [8:0] ins, input bit ld,
                       input logic [1:0] la, input logic [7:0] ldd, input bit rst);
    logic [7:0] res;
    logic [1:0] ra, rb;
    ex_t e;
    @(posedge clk);
    #1;
    reset = rst; in_valid = v; instr = ins; ld_en = ld; ld_addr = la; ld_data = ldd;
    if (rst) begin
      foreach (mR[i]) mR[i] = 8'h00;
      mzf = 1'b0; busy = 0; exp_ready = 1'b0;
    end else if (busy == 2) begin
      busy = 1; exp_ready = 1'b0;
    end else if (busy == 1) begin
      wb_q.push_back(pend); busy = 0; exp_ready = 1'b0;
    end else if (ld) begin
      mR[la] = ldd; exp_ready = 1'b0;
    end else begin
      exp_ready = 1'b1;
      if (v) begin
        ra = ins[3:2]; rb = ins[1:0];
        e.op = ins[8:7]; e.cmd = ins[6:4]; e.a = mR[ra]; e.b = mR[rb];
        exec_q.push_back(e);
        if (!(ins[8:7] == 2'b00 && ins[6:4] == 3'b110)) begin
          res = alu_f(ins[8:7], ins[6:4], mR[ra], mR[rb]);
          mR[ra] = res;
          mzf = (res == 8'h00);
        end
        pend.ra = ra; pend.val = mR[ra]; pend.zf = mzf;
        busy = 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'h0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic ld(input logic [1:0] a, input logic [7:0] d);
    cycle(1'b0, 9'h0, 1'b1, a, d, 1'b0);
  endtask

  task automatic issue(input logic [8:0] ins);
    cycle(1'b1, ins, 1'b0, 2'd0, 8'h00, 1'b0);
    idle(3);
  endtask

  // Monitor: owns dbg_addr; checks handshake, ALU presentation and writeback.
  ex_t er;
  wb_t held;
  bit  chk_dbg = 1'b0;
  bit  exec_nxt = 1'b0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (chk_dbg) begin
        chk("wb_reg", dbg_data, held.val);
        chk("wb_zero_flag", zero_flag, held.zf);
        chk_dbg = 1'b0;
      end
      chk("in_ready", in_ready, exp_ready);
      chk("done", done, wb_q.size() != 0);
      if (done && wb_q.size() != 0) begin
        held = wb_q.pop_front();
        dbg_addr = held.ra;
        chk_dbg = 1'b1;
      end
      if (exec_nxt) begin
        if (exec_q.size() == 0) begin
          chk("exec_unexpected", 1, 0);
        end else begin
          er = exec_q.pop_front();
          chk("exec_alu_op", ALU_Op, er.op);
          chk("exec_alu_cmd", alu_cmd, er.cmd);
          chk("exec_inA", inA, er.a);
          chk("exec_inB", inB, er.b);
        end
      end else begin
        chk("idle_alu_nop", {ALU_Op, alu_cmd, inA, inB}, {2'b00, 3'b110, 16'h0000});
      end
      exec_nxt = in_valid && in_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] ins;
    foreach (mR[i]) mR[i] = 8'h00;
    for (int i = 0; i < 3; i++) cycle(1'b0, 9'h0, 1'b0, 2'd0, 8'h00, 1'b1);
    // Reset contents seen through no-op writebacks.
    for (int r = 0; r < 4; r++) issue({2'b00, 3'b110, r[1:0], r[1:0]});

    ld(2'd0, 8'h3A); ld(2'd1, 8'h03);
    issue(9'b00_001_00_01);
    ld(2'd0, 8'h3A); ld(2'd1, 8'h3A);
    issue(9'b11_000_00_01);
    issue(9'b10_000_00_01);
    ld(2'd2, 8'h55);
    issue(9'b11_000_11_11);
    issue(9'b00_110_10_10);

    // Continuous in_valid: one acceptance every third cycle.
    for (int i = 0; i < 15; i++) cycle(1'b1, 9'($urandom), 1'b0, 2'd0, 8'h00, 1'b0);
    idle(3);

    // Load beats instruction, then loads in EXEC/WB are ignored.
    ld(2'd1, 8'h04);
    cycle(1'b1, 9'b00_000_10_01, 1'b1, 2'd2, 8'hAA, 1'b0);
    cycle(1'b1, 9'b00_000_10_01, 1'b0, 2'd0, 8'h00, 1'b0);
    cycle(1'b0, 9'h0, 1'b1, 2'd2, 8'h11, 1'b0);
    cycle(1'b0, 9'h0, 1'b1, 2'd2, 8'h22, 1'b0);
    idle(2);
    issue(9'b00_110_10_10);

    // Reset during EXEC aborts the instruction.
    ld(2'd3, 8'h7F);
    cycle(1'b1, 9'b10_000_11_00, 1'b0, 2'd0, 8'h00, 1'b0);
    cycle(1'b0, 9'h0, 1'b0, 2'd0, 8'h00, 1'b1);
    cycle(1'b0, 9'h0, 1'b0, 2'd0, 8'h00, 1'b1);
    idle(2);
    issue(9'b00_110_11_11);

    for (int i = 0; i < 800; i++) begin
      ins = 9'($urandom);
      if ($urandom_range(7) == 0) ins[8:4] = 5'b00110;
      cycle($urandom_range(3) != 0, ins, $urandom_range(4) == 0,
            2'($urandom), ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom), 1'b0);
    end
    idle(6);
    chk("exec_queue_drained", exec_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
